// File: rtl/uart_pkg.sv
// Shared UART constants: byte width and default receive FIFO depth.
// Imported by uart_rx, uart_tx and uart_byte_fifo so they agree on widths.
package uart_pkg;

  localparam int UART_DATA_W      = 8;
  localparam int UART_FIFO_ADDR_W = 4;

endpackage

// File: rtl/uart_fifo_mem.sv
// DATA_W x 2**ADDR_W register array: sync write port, async read port.
// Ports: clk, we, waddr, wdata (write); raddr -> rdata (combinational read).
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int ADDR_W = UART_FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_byte_fifo.sv
// First-word fall-through byte FIFO between uart_rx and the sink.
// Ports: clk, nreset (sync, active-low); in_* / out_* valid-ready
// handshakes; level = occupancy; overflow sticky, cleared by clear_ovf.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int ADDR_W = UART_FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  input  logic              clear_ovf
);

  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;

  // Extra wrap bit distinguishes full from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign level     = wr_ptr - rd_ptr;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  uart_fifo_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push && nreset),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (in_data),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (out_data)
  );

  always_ff @(posedge clk) begin
    if (!nreset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      // A new overflow in the same cycle as clear_ovf keeps the flag.
      if (in_valid && full) begin
        overflow <= 1'b1;
      end else if (clear_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_byte_fifo.sv
// Self-checking bench for uart_byte_fifo against a queue reference model.
// Directed test-plan steps followed by a randomized traffic phase.
module tb_uart_byte_fifo;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 2**AW;

  logic          clk = 1'b0;
  logic          nreset = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW:0]   level;
  logic          overflow;
  logic          clear_ovf = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] q[$];
  bit            ovf_m = 1'b0;

  always #5 clk = ~clk;

  uart_byte_fifo #(
    .DATA_W (DW),
    .ADDR_W (AW)
  ) dut (
    .clk       (clk),
    .nreset    (nreset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .overflow  (overflow),
    .clear_ovf (clear_ovf)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("level", {27'd0, level}, q.size());
    chk("out_valid", {31'd0, out_valid}, (q.size() != 0) ? 1 : 0);
    chk("in_ready", {31'd0, in_ready}, (q.size() != DEPTH) ? 1 : 0);
    chk("overflow", {31'd0, overflow}, {31'd0, ovf_m});
    if (q.size() != 0) begin
      chk("out_data", {24'd0, out_data}, {24'd0, q[0]});
    end
  endtask

  // Advance one clock; model decides from pre-edge state and inputs.
  task automatic tick();
    bit do_push, do_pop, set_ovf, rst;
    logic [DW-1:0] d;
    rst     = !nreset;
    d       = in_data;
    do_pop  = out_ready && (q.size() != 0);
    do_push = in_valid && (q.size() != DEPTH);
    set_ovf = in_valid && (q.size() == DEPTH);
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
      ovf_m = 1'b0;
    end else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(d);
      if (set_ovf) ovf_m = 1'b1;
      else if (clear_ovf) ovf_m = 1'b0;
    end
    check_model();
  endtask

  initial begin
    // Reset then idle
    nreset = 1'b0;
    tick();
    tick();
    nreset = 1'b1;
    chk("rst_level", {27'd0, level}, 0);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    chk("rst_overflow", {31'd0, overflow}, 0);
    tick();

    // Single byte
    in_valid = 1'b1;
    in_data  = 8'h61;
    tick();
    in_valid = 1'b0;
    chk("single_valid", {31'd0, out_valid}, 1);
    chk("single_data", {24'd0, out_data}, 32'h61);
    chk("single_level", {27'd0, level}, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("single_pop_valid", {31'd0, out_valid}, 0);
    chk("single_pop_level", {27'd0, level}, 0);

    // Fill and overflow
    in_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      in_data = 8'(i);
      tick();
    end
    chk("fill_level", {27'd0, level}, DEPTH);
    chk("fill_in_ready", {31'd0, in_ready}, 0);
    in_data = 8'hAA;
    tick();
    in_valid = 1'b0;
    chk("ovf_set", {31'd0, overflow}, 1);
    chk("ovf_level", {27'd0, level}, DEPTH);
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_order", {24'd0, out_data}, i);
      tick();
    end
    out_ready = 1'b0;
    chk("drain_empty", {31'd0, out_valid}, 0);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    chk("ovf_clear", {31'd0, overflow}, 0);

    // Concurrent streaming, pointers wrap
    in_valid = 1'b1;
    in_data  = 8'h40;
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      in_data = 8'(8'h41 + i);
      tick();
      chk("stream_level", {27'd0, level}, 1);
      chk("stream_data", {24'd0, out_data}, 32'(8'(8'h41 + i)));
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    chk("stream_end", {31'd0, out_valid}, 0);

    // Full with simultaneous pop
    in_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      in_data = 8'($urandom_range(0, 255));
      tick();
    end
    in_data   = 8'h55;
    out_ready = 1'b1;
    tick();
    chk("fullpop_level", {27'd0, level}, DEPTH - 1);
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("fullpop_push", {27'd0, level}, DEPTH);
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH - 1; i++) tick();
    chk("fullpop_last", {24'd0, out_data}, 32'h55);
    tick();
    out_ready = 1'b0;
    chk("fullpop_empty", {31'd0, out_valid}, 0);

    // Reset mid-operation
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 8'(8'hC0 + i);
      tick();
    end
    in_valid = 1'b0;
    chk("mid_level5", {27'd0, level}, 5);
    nreset = 1'b0;
    tick();
    nreset = 1'b1;
    chk("mid_rst_level", {27'd0, level}, 0);
    chk("mid_rst_valid", {31'd0, out_valid}, 0);
    in_valid = 1'b1;
    in_data  = 8'h7A;
    tick();
    in_valid = 1'b0;
    chk("mid_first", {24'd0, out_data}, 32'h7A);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 45);
      clear_ovf = ($urandom_range(0, 99) < 5);
      nreset    = ($urandom_range(0, 199) != 0);
      in_data   = 8'($urandom);
      tick();
    end
    nreset    = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clear_ovf = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
